// File: rtl/core_inst_sequencer_if.sv
// Host/core side bundle of the instruction sequencer: start/mode in, ofifo_valid from the core,
// registered instruction word and status out.
interface core_inst_sequencer_if;
  logic        start;
  logic [1:0]  mode;
  logic        ofifo_valid;
  logic [33:0] inst;
  logic [3:0]  kij_idx;
  logic        busy;
  logic        done;

  modport master (output start, mode, ofifo_valid, input inst, kij_idx, busy, done);
  modport slave  (input start, mode, ofifo_valid, output inst, kij_idx, busy, done);
endinterface

// File: rtl/core_inst_sequencer.sv
// Instruction sequencer for the systolic core: per kij weight load, kernel load, gap, activation load,
// execute and OFIFO drain to pmem, followed by the psum accumulation pass over every output pixel.
module core_inst_sequencer #(
  parameter int             ROW    = 8,
  parameter int             COL    = 8,
  parameter int             IN_W   = 6,
  parameter int             KS     = 3,
  parameter int             OUT_W  = IN_W - KS + 1,
  parameter int             AW     = 11,
  parameter logic [AW-1:0]  W_BASE = 11'h400,
  parameter logic [AW-1:0]  P_BASE = 11'h000,
  parameter int             GAP    = 10
) (
  input logic                  clk,
  input logic                  reset,
  core_inst_sequencer_if.slave bus
);
  localparam int LEN_NIJ = IN_W * IN_W;
  localparam int LEN_KIJ = KS * KS;
  localparam int M1      = (COL > GAP) ? COL : GAP;
  localparam int CNT_MAX = (M1 > LEN_NIJ + 1) ? M1 : LEN_NIJ + 1;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int JW      = $clog2(LEN_KIJ + 2);
  localparam int KW      = $clog2(KS + 1);
  localparam int OW      = $clog2(OUT_W + 1);

  typedef logic [AW-1:0] addr_t;
  localparam logic [33:0] IDLE_INST = {1'b0, 1'b1, 1'b1, {AW{1'b0}}, 1'b1, 1'b1, {AW{1'b0}}, 7'b0};

  if (ROW < 1 || COL < 1 || KS > IN_W || AW != 11) begin : g_param_check
    $error("core_inst_sequencer: unsupported parameter set");
  end

  typedef enum logic [2:0] {S_IDLE, S_WL0, S_KLD, S_GAP, S_AL0, S_EXE, S_ORD, S_ACC} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      kij_q, kij_d;
  logic [1:0]      mode_q, mode_d;
  logic [JW-1:0]   j_q, j_d;
  logic [KW-1:0]   ki_q, ki_d, kj_q, kj_d;
  logic [OW-1:0]   orow_q, orow_d, ocol_q, ocol_d;
  logic [33:0]     inst_q, inst_d;
  logic            busy_q, busy_d, done_q, done_d;

  logic  acc, cen_p, wen_p, cen_x, wen_x, ofifo_rd, l0_rd, l0_wr, execute, load;
  addr_t a_p, a_x;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    kij_d   = kij_q;
    mode_d  = mode_q;
    j_d     = j_q;
    ki_d    = ki_q;
    kj_d    = kj_q;
    orow_d  = orow_q;
    ocol_d  = ocol_q;
    done_d  = 1'b0;
    acc = 1'b0; cen_p = 1'b1; wen_p = 1'b1; a_p = '0;
    cen_x = 1'b1; wen_x = 1'b1; a_x = '0;
    ofifo_rd = 1'b0; l0_rd = 1'b0; l0_wr = 1'b0; execute = 1'b0; load = 1'b0;

    unique case (state_q)
      S_IDLE: if (bus.start) begin
        mode_d = bus.mode;
        cnt_d  = '0;
        kij_d  = '0;
        j_d = '0; ki_d = '0; kj_d = '0; orow_d = '0; ocol_d = '0;
        state_d = (bus.mode == 2'd2) ? S_ACC : S_WL0;
      end
      // xmem data arrives one cycle after its address, so l0_wr trails the reads by one cycle
      S_WL0: begin
        if (cnt_q < CW'(COL)) begin
          cen_x = 1'b0;
          a_x   = W_BASE + addr_t'(kij_q) * addr_t'(COL) + addr_t'(cnt_q);
        end
        l0_wr = (cnt_q != '0);
        if (cnt_q == CW'(COL)) begin cnt_d = '0; state_d = S_KLD; end
        else cnt_d = cnt_q + 1'b1;
      end
      S_KLD: begin
        l0_rd = 1'b1;
        load  = 1'b1;
        if (cnt_q == CW'(COL - 1)) begin cnt_d = '0; state_d = S_GAP; end
        else cnt_d = cnt_q + 1'b1;
      end
      S_GAP: begin
        if (cnt_q == CW'(GAP - 1)) begin cnt_d = '0; state_d = S_AL0; end
        else cnt_d = cnt_q + 1'b1;
      end
      S_AL0: begin
        if (cnt_q < CW'(LEN_NIJ)) begin
          cen_x = 1'b0;
          a_x   = addr_t'(cnt_q);
        end
        l0_wr = (cnt_q != '0);
        if (cnt_q == CW'(LEN_NIJ)) begin cnt_d = '0; state_d = S_EXE; end
        else cnt_d = cnt_q + 1'b1;
      end
      S_EXE: begin
        l0_rd   = 1'b1;
        execute = 1'b1;
        if (cnt_q == CW'(LEN_NIJ - 1)) begin cnt_d = '0; state_d = S_ORD; end
        else cnt_d = cnt_q + 1'b1;
      end
      S_ORD: if (bus.ofifo_valid) begin
        ofifo_rd = 1'b1;
        cen_p    = 1'b0;
        wen_p    = 1'b0;
        a_p      = P_BASE + addr_t'(kij_q) * addr_t'(LEN_NIJ) + addr_t'(cnt_q);
        if (cnt_q == CW'(LEN_NIJ - 1)) begin
          cnt_d = '0;
          if (kij_q != 4'(LEN_KIJ - 1)) begin
            kij_d   = kij_q + 1'b1;
            state_d = S_WL0;
          end else if (mode_q == 2'd1) begin
            kij_d   = '0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_ACC;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      // j walks the kernel taps; ki/kj track j/KS and j%KS so the address needs no divider
      S_ACC: begin
        acc = (j_q != '0) && (j_q <= JW'(LEN_KIJ));
        if (j_q < JW'(LEN_KIJ)) begin
          cen_p = 1'b0;
          a_p   = P_BASE + addr_t'(j_q) * addr_t'(LEN_NIJ)
                + (addr_t'(orow_q) + addr_t'(ki_q)) * addr_t'(IN_W)
                + addr_t'(ocol_q) + addr_t'(kj_q);
          if (kj_q == KW'(KS - 1)) begin kj_d = '0; ki_d = ki_q + 1'b1; end
          else kj_d = kj_q + 1'b1;
        end
        if (j_q == JW'(LEN_KIJ + 1)) begin
          j_d = '0; ki_d = '0; kj_d = '0;
          if (ocol_q == OW'(OUT_W - 1)) begin
            ocol_d = '0;
            if (orow_q == OW'(OUT_W - 1)) begin
              orow_d  = '0;
              kij_d   = '0;
              done_d  = 1'b1;
              state_d = S_IDLE;
            end else begin
              orow_d = orow_q + 1'b1;
            end
          end else begin
            ocol_d = ocol_q + 1'b1;
          end
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    inst_d = {acc, cen_p, wen_p, a_p, cen_x, wen_x, a_x, ofifo_rd, 1'b0, 1'b0, l0_rd, l0_wr, execute, load};
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      kij_q  <= '0;
      mode_q <= '0;
      j_q    <= '0;
      ki_q   <= '0;
      kj_q   <= '0;
      orow_q <= '0;
      ocol_q <= '0;
      inst_q <= IDLE_INST;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      kij_q  <= kij_d;
      mode_q <= mode_d;
      j_q    <= j_d;
      ki_q   <= ki_d;
      kj_q   <= kj_d;
      orow_q <= orow_d;
      ocol_q <= ocol_d;
      inst_q <= inst_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign bus.inst    = inst_q;
  assign bus.kij_idx = kij_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
endmodule

// File: tb/tb_core_inst_sequencer.sv
// Directed bench for core_inst_sequencer: table of whole-run scenarios plus hand-written
// sequences for reset mid-run and individual address spot checks.
module tb_core_inst_sequencer;
  localparam logic [33:0] IDLE_INST = 34'h1_800C_0000;

  logic clk;
  logic reset;
  core_inst_sequencer_if bus ();

  core_inst_sequencer dut (.clk(clk), .reset(reset), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0] mode;
    bit         toggle;
    int         busy;
    int         pwr;
    int         xrd;
    int         accn;
  } vec_t;

  vec_t  tbl   [5];
  string names [5];

  logic [10:0] xexp[$];
  logic [10:0] aexp[$];
  logic [10:0] rdq[$];
  logic [10:0] acc2_q[$];

  int busy_n, pwr_n, pseq_err, xrd_n, xaddr_err, lag_err, acc_n, aaddr_err, alag_err, done_n;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic build_expect(input logic [1:0] m);
    xexp.delete();
    aexp.delete();
    if (m != 2'd2) begin
      for (int k = 0; k < 9; k++) begin
        for (int t = 0; t < 8; t++) xexp.push_back(11'(11'h400 + k * 8 + t));
        for (int a = 0; a < 36; a++) xexp.push_back(11'(a));
      end
    end
    if (m != 2'd1) begin
      for (int orow = 0; orow < 4; orow++)
        for (int ocol = 0; ocol < 4; ocol++)
          for (int ki = 0; ki < 3; ki++)
            for (int kj = 0; kj < 3; kj++)
              aexp.push_back(11'((ki * 3 + kj) * 36 + (orow + ki) * 6 + ocol + kj));
    end
  endtask

  task automatic run_case(input string nm, input vec_t v);
    logic [33:0] i;
    logic prev_x, prev_r, cenx, cenp, wenp;
    int xi, ri;
    build_expect(v.mode);
    rdq.delete();
    busy_n = 0; pwr_n = 0; pseq_err = 0; xrd_n = 0; xaddr_err = 0;
    lag_err = 0; acc_n = 0; aaddr_err = 0; alag_err = 0; done_n = 0;
    xi = 0; ri = 0; prev_x = 1'b0; prev_r = 1'b0;
    bus.mode = v.mode;
    bus.ofifo_valid = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      bus.ofifo_valid = v.toggle ? c[0] : 1'b1;
      if (c == 1) bus.mode = v.mode ^ 2'b11;
      if (c == 50) bus.start = 1'b1;
      if (c == 51) bus.start = 1'b0;
      i = bus.inst;
      cenx = i[19]; cenp = i[32]; wenp = i[31];
      if (bus.busy) busy_n++;
      if (!cenx) begin
        xrd_n++;
        if (i[18] !== 1'b1 || xi >= xexp.size() || i[17:7] !== xexp[xi]) xaddr_err++;
        xi++;
      end
      if (i[2] !== prev_x) lag_err++;
      prev_x = !cenx;
      if (!cenp && !wenp) begin
        if (i[30:20] !== 11'(pwr_n) || i[6] !== 1'b1) pseq_err++;
        pwr_n++;
      end else if (i[6]) begin
        pseq_err++;
      end
      if (!cenp && wenp) begin
        rdq.push_back(i[30:20]);
        if (ri >= aexp.size() || i[30:20] !== aexp[ri]) aaddr_err++;
        ri++;
      end
      if (i[33] !== prev_r) alag_err++;
      if (i[33]) acc_n++;
      prev_r = !cenp && wenp;
      if (bus.done) begin
        done_n++;
        break;
      end
      @(negedge clk);
    end
    check({nm, "_busy_cycles"}, busy_n, v.busy);
    check({nm, "_pmem_writes"}, pwr_n, v.pwr);
    check({nm, "_pmem_wr_seq"}, pseq_err, 0);
    check({nm, "_xmem_reads"}, xrd_n, v.xrd);
    check({nm, "_xmem_addr"}, xaddr_err, 0);
    check({nm, "_l0wr_lag"}, lag_err, 0);
    check({nm, "_acc_cycles"}, acc_n, v.accn);
    check({nm, "_acc_addr"}, aaddr_err, 0);
    check({nm, "_acc_lag"}, alag_err, 0);
    check({nm, "_done_seen"}, done_n, 1);
    @(negedge clk);
    check({nm, "_post_done"}, bus.done, 1'b0);
    check({nm, "_post_busy"}, bus.busy, 1'b0);
    check({nm, "_post_inst"}, bus.inst, IDLE_INST);
    check({nm, "_post_kij"}, bus.kij_idx, 4'd0);
    if (v.mode == 2'd2) acc2_q = rdq;
  endtask

  initial begin
    int idle_bad;
    tbl[0] = '{mode: 2'd1, toggle: 1'b0, busy: 1224, pwr: 324, xrd: 396, accn: 0};   names[0] = "conv_only";
    tbl[1] = '{mode: 2'd0, toggle: 1'b0, busy: 1400, pwr: 324, xrd: 396, accn: 144}; names[1] = "full";
    tbl[2] = '{mode: 2'd2, toggle: 1'b0, busy: 176,  pwr: 0,   xrd: 0,   accn: 144}; names[2] = "acc_only";
    tbl[3] = '{mode: 2'd0, toggle: 1'b1, busy: 1724, pwr: 324, xrd: 396, accn: 144}; names[3] = "full_toggle";
    tbl[4] = '{mode: 2'd3, toggle: 1'b0, busy: 1400, pwr: 324, xrd: 396, accn: 144}; names[4] = "mode3";

    bus.start = 1'b0;
    bus.mode = 2'd0;
    bus.ofifo_valid = 1'b0;
    reset = 1'b1;
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_inst", bus.inst, IDLE_INST);
    check("reset_busy", bus.busy, 1'b0);
    check("reset_done", bus.done, 1'b0);
    check("reset_kij", bus.kij_idx, 4'd0);
    reset = 1'b1;
    @(negedge clk);

    for (int n = 0; n < 5; n++) run_case(names[n], tbl[n]);

    check("acc_px5_count", acc2_q.size(), 144);
    if (acc2_q.size() == 144) begin
      check("acc_px5_j0", acc2_q[45], 11'd7);
      check("acc_px5_j1", acc2_q[46], 11'd44);
      check("acc_px5_j2", acc2_q[47], 11'd81);
      check("acc_px5_j8", acc2_q[53], 11'd309);
    end

    // reset asserted in the middle of EXE for kij 0
    bus.mode = 2'd0;
    bus.ofifo_valid = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (80) @(negedge clk);
    check("pre_reset_execute", bus.inst[1], 1'b1);
    reset = 1'b0;
    #1;
    check("midrun_reset_inst", bus.inst, IDLE_INST);
    check("midrun_reset_busy", bus.busy, 1'b0);
    check("midrun_reset_kij", bus.kij_idx, 4'd0);
    check("midrun_reset_done", bus.done, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    idle_bad = 0;
    repeat (150) begin
      @(negedge clk);
      if (bus.busy !== 1'b0 || bus.inst !== IDLE_INST) idle_bad++;
    end
    check("no_resume_without_start", idle_bad, 0);
    bus.mode = 2'd1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("restart_busy", bus.busy, 1'b1);
    @(negedge clk);
    check("restart_first_xaddr", {bus.inst[19], bus.inst[17:7]}, {1'b0, 11'h400});
    reset = 1'b0;
    #1;
    check("final_reset_busy", bus.busy, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
